xor_vector_seq: RTL and testbench
=================================

XOR_VECTOR_SEQ -- requirements
Module: xor_vector_seq

Interface
REQ-001 Parameter HOLD_CYCLES, default 10, cycles each input vector is held before sampling (legal range 1..255).
REQ-002 Parameter CNT_W, default 8, hold-counter width; it SHALL satisfy HOLD_CYCLES <= 2**CNT_W-1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 start  input  1  one-cycle request to run the 4-vector sweep.
REQ-006 a  input  1  result returned by the downstream cmos_xor gate.
REQ-007 x  output  1  first gate operand, registered.
REQ-008 y  output  1  second gate operand, registered.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  high from sweep completion until next start or reset.
REQ-011 pass  output  1  valid while done; high when err_count is 0.
REQ-012 err_count  output  3  number of mismatching vectors in the last sweep (0..4).
REQ-013 vec_idx  output  2  index of the vector currently driven; x=vec_idx[1], y=vec_idx[0].

Function
REQ-014 FSM states SHALL be IDLE, DRIVE, SAMPLE, FIN.
REQ-015 IDLE: start=1 -> DRIVE; vec_idx<=0, err_count<=0, done<=0, hold counter<=HOLD_CYCLES-1.
REQ-016 DRIVE: x,y driven from vec_idx; counter decrements each cycle; at counter==0 -> SAMPLE.
REQ-017 SAMPLE (one cycle): compare a to x^y; on mismatch err_count<=err_count+1.
REQ-018 SAMPLE with vec_idx<3 -> DRIVE, vec_idx+1, counter reloaded; with vec_idx==3 -> FIN.
REQ-019 FIN: done=1, busy=0, pass=(err_count==0); start=1 -> restart exactly as in REQ-015.
REQ-020 Sweep order SHALL be 00,01,10,11; start-to-done latency SHALL be 4*(HOLD_CYCLES+1)+1 cycles.
REQ-021 start while busy SHALL be ignored (no restart, no counter effect).
REQ-022 x,y SHALL hold steady for all HOLD_CYCLES+1 cycles of a vector, including the SAMPLE cycle.
REQ-023 busy=1 exactly in DRIVE and SAMPLE.
REQ-024 err_count SHALL never exceed 4; no wrap.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE, x=0, y=0, vec_idx=0, err_count=0, busy=0, done=0, pass=0, counter=0.
REQ-026 Reset mid-sweep SHALL abandon the sweep with no done pulse; start accepted the cycle after rst_n returns high.

Configuration
REQ-027 Macro XOR_SEQ_FAIL_CAPTURE_EN defined: extra outputs fail_valid (1) and fail_vec (2) latch the vec_idx of the first mismatching vector per sweep, cleared on start and reset.
REQ-028 Macro undefined: fail_valid/fail_vec ports and their logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package xor_seq_pkg SHALL hold the state enumeration, NUM_VECTORS=4 and the default HOLD_CYCLES.
REQ-030 Hold counter SHALL be a sub-module hold_timer (load, decrement, zero flag); FSM and compare stay in xor_vector_seq.

Verification
REQ-031 Correct XOR model on a, HOLD_CYCLES=10, pulse start -> done after 45 cycles, pass=1, err_count=0.
REQ-032 a forced to 0 -> done, pass=0, err_count=2; with macro, fail_vec=01, fail_valid=1.
REQ-033 a = XNOR model -> err_count=4, pass=0; with macro, fail_vec=00.
REQ-034 start pulsed again in cycle 20 of a sweep -> ignored; done still at cycle 45 from first start.
REQ-035 rst_n low in DRIVE of vector 2 -> next cycle IDLE, all outputs 0; new start completes a full 45-cycle sweep.
REQ-036 HOLD_CYCLES=1, start in FIN -> immediate restart, done low, err_count 0, done again 9 cycles later.

Source files
------------

// File: rtl/xor_seq_pkg.sv
// Shared definitions for the XOR gate sweep sequencer: FSM states, vector count
// and the default hold time.
package xor_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FIN    = 2'd3
    } state_t;

    localparam int NUM_VECTORS         = 4;
    localparam int DEFAULT_HOLD_CYCLES = 10;

endpackage

// File: rtl/xor_vector_seq_hold_timer.sv
// Loadable down-counter with a zero flag; paces how long each vector is held.
module hold_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/xor_vector_seq.sv
// Sweeps the four 2-bit operand vectors through an external XOR gate and counts
// wrong answers. Optional first-failure capture is enabled by XOR_SEQ_FAIL_CAPTURE_EN.
module xor_vector_seq
    import xor_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       a,
    output logic       x,
    output logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
`ifdef XOR_SEQ_FAIL_CAPTURE_EN
    output logic       fail_valid,
    output logic [1:0] fail_vec,
`endif
    output logic [1:0] vec_idx
);

    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [1:0]       LAST_VEC = 2'(NUM_VECTORS - 1);
    localparam logic [2:0]       MAX_ERR  = 3'(NUM_VECTORS);

    state_t state, next_state;
    logic   start_acc;
    logic   mismatch;
    logic   tmr_load;
    logic   tmr_dec;
    logic   tmr_zero;

    // Start is honoured only when no sweep is running.
    assign start_acc = start && ((state == IDLE) || (state == FIN));
    assign mismatch  = (state == SAMPLE) && (a != (x ^ y));
    assign tmr_load  = start_acc || ((state == SAMPLE) && (vec_idx != LAST_VEC));
    assign tmr_dec   = (state == DRIVE);

    hold_timer #(
        .CNT_W(CNT_W)
    ) u_hold_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .dec     (tmr_dec),
        .load_val(RELOAD),
        .zero    (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start)    next_state = DRIVE;
            DRIVE:   if (tmr_zero) next_state = SAMPLE;
            SAMPLE:  next_state = (vec_idx == LAST_VEC) ? FIN : DRIVE;
            FIN:     if (start)    next_state = DRIVE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == DRIVE) || (state == SAMPLE);
        done = (state == FIN);
        pass = (state == FIN) && (err_count == '0);
    end

    // x/y change together with vec_idx, so they stay put through the SAMPLE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_idx   <= '0;
            x         <= 1'b0;
            y         <= 1'b0;
            err_count <= '0;
        end else if (start_acc) begin
            vec_idx   <= '0;
            x         <= 1'b0;
            y         <= 1'b0;
            err_count <= '0;
        end else if (state == SAMPLE) begin
            if (mismatch && (err_count < MAX_ERR)) begin
                err_count <= err_count + 3'd1;
            end
            if (vec_idx != LAST_VEC) begin
                vec_idx <= vec_idx + 2'd1;
                x       <= (vec_idx + 2'd1) >> 1 != 2'd0;
                y       <= ~vec_idx[0];
            end
        end
    end

`ifdef XOR_SEQ_FAIL_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (!rst_n || start_acc) begin
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_vec   <= vec_idx;
        end
    end
`endif

endmodule

// File: tb/tb_xor_vector_seq.sv
// Directed bench for xor_vector_seq: HOLD_CYCLES=10 and HOLD_CYCLES=1 instances,
// good / stuck-at-0 / XNOR gate models. Honours XOR_SEQ_FAIL_CAPTURE_EN.
module tb_xor_vector_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       a;
    logic       x, y, busy, done, pass;
    logic [2:0] err_count;
    logic [1:0] vec_idx;
    int         mode;

    logic       d1_rst_n;
    logic       d1_start;
    logic       d1_a;
    logic       d1_x, d1_y, d1_busy, d1_done, d1_pass;
    logic [2:0] d1_err_count;
    logic [1:0] d1_vec_idx;
    int         d1_mode;

`ifdef XOR_SEQ_FAIL_CAPTURE_EN
    logic       fail_valid, d1_fail_valid;
    logic [1:0] fail_vec, d1_fail_vec;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Downstream gate models: 0 = XOR, 1 = stuck at 0, 2 = XNOR
    assign a    = (mode == 0)    ? (x ^ y)       : (mode == 1)    ? 1'b0 : ~(x ^ y);
    assign d1_a = (d1_mode == 0) ? (d1_x ^ d1_y) : (d1_mode == 1) ? 1'b0 : ~(d1_x ^ d1_y);

    xor_vector_seq #(.HOLD_CYCLES(10), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .x         (x),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
`ifdef XOR_SEQ_FAIL_CAPTURE_EN
        .fail_valid(fail_valid),
        .fail_vec  (fail_vec),
`endif
        .vec_idx   (vec_idx)
    );

    xor_vector_seq #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
        .clk       (clk),
        .rst_n     (d1_rst_n),
        .start     (d1_start),
        .a         (d1_a),
        .x         (d1_x),
        .y         (d1_y),
        .busy      (d1_busy),
        .done      (d1_done),
        .pass      (d1_pass),
        .err_count (d1_err_count),
`ifdef XOR_SEQ_FAIL_CAPTURE_EN
        .fail_valid(d1_fail_valid),
        .fail_vec  (d1_fail_vec),
`endif
        .vec_idx   (d1_vec_idx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"},  err_count, 0);
        check({tag, "_vec"},  vec_idx, 0);
        check({tag, "_xy"},   {x, y}, 0);
    endtask

    // Full sweep on the HOLD_CYCLES=10 instance; done must appear on the 45th edge
    // counting the one that samples start. poke_n re-pulses start mid-sweep (0 = never).
    task automatic run_sweep(input int md, input int poke_n, input logic [2:0] exp_err,
                             input logic [1:0] exp_fv);
        logic [1:0] ev;
        mode  = md;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 44; n++) begin
            ev = 2'((n - 1) / 11);
            check("sw_busy", busy, 1);
            check("sw_done", done, 0);
            check("sw_vec",  vec_idx, ev);
            check("sw_xy",   {x, y}, ev);
            if (n == poke_n) start = 1'b1;
            tick();
            start = 1'b0;
        end
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_err",  err_count, exp_err);
        check("end_pass", pass, (exp_err == 0));
`ifdef XOR_SEQ_FAIL_CAPTURE_EN
        check("end_fvalid", fail_valid, (exp_err != 0));
        if (exp_err != 0) check("end_fvec", fail_vec, exp_fv);
`else
        if (exp_fv != 2'd0 && exp_err == 0) check("end_fv_unused", exp_fv, 0);
`endif
        tick();
        check("fin_hold_done", done, 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        mode     = 0;
        d1_rst_n = 1'b0;
        d1_start = 1'b0;
        d1_mode  = 2;
        tick();
        tick();
        check_idle("rst");
        rst_n    = 1'b1;
        d1_rst_n = 1'b1;
        tick();
        check_idle("post_rst");

        run_sweep(0, 0,  3'd0, 2'd0);   // good gate
        run_sweep(1, 0,  3'd2, 2'd1);   // stuck at 0: vectors 01 and 10 fail
        run_sweep(2, 0,  3'd4, 2'd0);   // XNOR: every vector fails
        run_sweep(0, 20, 3'd0, 2'd0);   // start during sweep ignored

        // Reset while vector 2 is being driven
        mode  = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n < 25; n++) tick();
        check("pre_rst_vec", vec_idx, 2);
        check("pre_rst_err", err_count, 2);
        rst_n = 1'b0;
        tick();
        check_idle("mid_rst");
        rst_n = 1'b1;
        tick();
        check_idle("mid_rst_rel");
        run_sweep(0, 0, 3'd0, 2'd0);

        // HOLD_CYCLES=1 instance: 9-edge sweep, then restart straight from FIN
        d1_start = 1'b1;
        tick();
        d1_start = 1'b0;
        check("h1_busy", d1_busy, 1);
        for (int n = 1; n < 8; n++) tick();
        check("h1_pre_done", d1_done, 0);
        check("h1_pre_vec", d1_vec_idx, 3);
        tick();
        check("h1_done", d1_done, 1);
        check("h1_err",  d1_err_count, 4);
        check("h1_pass", d1_pass, 0);
        d1_mode  = 0;
        d1_start = 1'b1;
        tick();
        d1_start = 1'b0;
        check("h1_rs_done", d1_done, 0);
        check("h1_rs_busy", d1_busy, 1);
        check("h1_rs_err",  d1_err_count, 0);
        check("h1_rs_vec",  d1_vec_idx, 0);
`ifdef XOR_SEQ_FAIL_CAPTURE_EN
        check("h1_rs_fvalid", d1_fail_valid, 0);
`endif
        for (int n = 1; n < 8; n++) tick();
        check("h1_rs_pre_done", d1_done, 0);
        tick();
        check("h1_rs_done2", d1_done, 1);
        check("h1_rs_pass",  d1_pass, 1);
        check("h1_rs_err2",  d1_err_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
